uart_baud_ctrl: RTL and testbench

//   Run/stop and divisor-change sequencer for the UART baud generator (free-running

---
 rtl/uart_baud_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_baud_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_ctrl.sv
// Run/stop and divisor-change sequencer for the UART baud generator.
// Optional idle-wait timeout is built in when UART_BAUD_TIMEOUT_EN is defined.
module uart_baud_ctrl #(
    parameter int          BITS          = 16,
    parameter int unsigned DEFAULT_DIV   = 650,
    parameter int          TIMEOUT_TICKS = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            cfg_valid,
    input  logic [BITS-1:0] cfg_div,
    output logic            cfg_ready,
    input  logic            link_busy,
    input  logic            bg_done,
    output logic            bg_enable,
    output logic [BITS-1:0] bg_final_value,
    output logic            baud_tick,
    output logic            running,
    output logic            cfg_timeout
);

    typedef enum logic [2:0] {
        STOP,
        RUN,
        WAIT_IDLE,
        SWAP,
        DRAIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [BITS-1:0] cur_div;
    logic [BITS-1:0] pend_div;
    logic            pend_vld;
    logic            accept;
    logic            load_cfg;
    logic            load_pend;
    logic            apply_pend;
    logic            to_hit;

    assign bg_enable      = (state != STOP);
    assign running        = (state != STOP);
    assign cfg_ready      = (state == STOP) || (state == RUN);
    assign bg_final_value = cur_div;
    assign baud_tick      = bg_done & bg_enable;
    assign accept         = cfg_valid & cfg_ready;

    always_comb begin
        state_nxt  = state;
        load_cfg   = 1'b0;
        load_pend  = 1'b0;
        apply_pend = 1'b0;
        unique case (state)
            STOP: begin
                load_cfg = accept;
                if (run) state_nxt = RUN;
            end
            RUN: begin
                if (accept) begin
                    load_pend = 1'b1;
                    state_nxt = WAIT_IDLE;
                end
                if (!run) state_nxt = DRAIN;
            end
            WAIT_IDLE: begin
                if (!run) state_nxt = DRAIN;
                else if (!link_busy || to_hit) state_nxt = SWAP;
            end
            SWAP: begin
                // The swap tick is the last tick of the old period
                if (baud_tick) begin
                    apply_pend = 1'b1;
                    state_nxt  = run ? RUN : STOP;
                end
            end
            DRAIN: begin
                if (baud_tick) begin
                    apply_pend = pend_vld;
                    state_nxt  = STOP;
                end
            end
            default: state_nxt = STOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= STOP;
            cur_div  <= BITS'(DEFAULT_DIV);
            pend_div <= '0;
            pend_vld <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_cfg) cur_div <= cfg_div;
            else if (apply_pend) cur_div <= pend_div;
            if (load_pend) begin
                pend_div <= cfg_div;
                pend_vld <= 1'b1;
            end else if (apply_pend) begin
                pend_vld <= 1'b0;
            end
        end
    end

`ifdef UART_BAUD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] to_cnt;
    logic          to_pulse;

    assign to_hit = (state == WAIT_IDLE) && baud_tick &&
                    (to_cnt == TW'(TIMEOUT_TICKS - 1));
    assign cfg_timeout = to_pulse;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt   <= '0;
            to_pulse <= 1'b0;
        end else begin
            if (state != WAIT_IDLE) to_cnt <= '0;
            else if (baud_tick) to_cnt <= to_cnt + 1'b1;
            // Pulse only when the limit, not an idle link, forced the swap
            to_pulse <= to_hit && run && link_busy;
        end
    end
`else
    // Timeout limit has no effect without the counter
    assign to_hit      = (TIMEOUT_TICKS < 0);
    assign cfg_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Self-checking bench for uart_baud_ctrl with a behavioural baud generator.
// Tick timing is predicted from divisor values and the apply-at-tick rules.
module tb_uart_baud_ctrl;

    localparam int BITS = 16;
    localparam int TO   = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            run;
    logic            cfg_valid;
    logic [BITS-1:0] cfg_div;
    logic            cfg_ready;
    logic            link_busy;
    logic            bg_done;
    logic            bg_enable;
    logic [BITS-1:0] bg_final_value;
    logic            baud_tick;
    logic            running;
    logic            cfg_timeout;

    logic [BITS-1:0] gcount;
    int cyc = 0;
    int to_pulses = 0;
    int checks = 0;
    int errors = 0;

    uart_baud_ctrl #(
        .BITS(BITS),
        .DEFAULT_DIV(650),
        .TIMEOUT_TICKS(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .cfg_valid(cfg_valid),
        .cfg_div(cfg_div),
        .cfg_ready(cfg_ready),
        .link_busy(link_busy),
        .bg_done(bg_done),
        .bg_enable(bg_enable),
        .bg_final_value(bg_final_value),
        .baud_tick(baud_tick),
        .running(running),
        .cfg_timeout(cfg_timeout)
    );

    always #5 clk = ~clk;

    // Free-running generator: ticks at final_value, wraps to 0
    always @(posedge clk or posedge reset) begin
        if (reset) gcount <= '0;
        else if (bg_enable)
            gcount <= (gcount == bg_final_value) ? '0 : gcount + 16'd1;
    end
    assign bg_done = (gcount == bg_final_value);

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cfg_timeout === 1'b1) to_pulses++;

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_tick(output int n);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (baud_tick !== 1'b1 && k < 4000);
        if (baud_tick !== 1'b1) check("tick_wait", 0, 1);
        n = cyc;
    endtask

    task automatic wait_stop();
        int k = 0;
        while (running !== 1'b0 && k < 4000) begin
            @(negedge clk);
            k++;
        end
        check("stop_reached", int'(running), 0);
    endtask

    // Enable rises, then the first tick is consumed DIV+1 edges later
    task automatic start_and_measure(input int d, input string tag);
        int en_n, t1, t2;
        run = 1'b1;
        @(negedge clk);
        check({tag, "_enable"}, int'(bg_enable), 1);
        en_n = cyc;
        wait_tick(t1);
        check({tag, "_first"}, t1 + 1 - en_n, d + 1);
        wait_tick(t2);
        check({tag, "_period"}, t2 - t1, d + 1);
    endtask

    initial begin
        int t, t2, last, ts, tn, dc, d2, d3, df, len, k, p0;
        reset     = 1'b1;
        run       = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        link_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_enable", int'(bg_enable), 0);
        check("rst_ready", int'(cfg_ready), 1);
        check("rst_running", int'(running), 0);
        check("rst_timeout", int'(cfg_timeout), 0);
        check("rst_div", int'(bg_final_value), 650);
        reset = 1'b0;
        @(negedge clk);
        check("idle_enable", int'(bg_enable), 0);

        start_and_measure(650, "dflt");

        run = 1'b0;
        wait_stop();
        cfg_valid = 1'b1;
        cfg_div   = 16'd9;
        check("stop_ready", int'(cfg_ready), 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("stop_div", int'(bg_final_value), 9);
        check("stop_enable", int'(bg_enable), 0);
        start_and_measure(9, "div9");
        dc = 9;

        wait_tick(t);
        for (int i = 0; i < 3; i++) begin
            d2  = (i == 0) ? 3 : (i == 1) ? 0 : $urandom_range(1, 20);
            len = (i == 0) ? 50 : $urandom_range(5, 60);
            last = t;
            cfg_valid = 1'b1;
            cfg_div   = 16'(d2);
            link_busy = 1'b1;
            check("busy_accept", int'(cfg_ready), 1);
            for (int j = 0; j < len; j++) begin
                @(negedge clk);
                if (j == 0) cfg_valid = 1'b0;
                if (baud_tick === 1'b1) begin
                    check("busy_period", cyc - last, dc + 1);
                    last = cyc;
                end
            end
            check("busy_ready", int'(cfg_ready), 0);
            check("busy_div", int'(bg_final_value), dc);
            link_busy = 1'b0;
            wait_tick(ts);
            check("swap_tick", ts - last, dc + 1);
            wait_tick(tn);
            check("new_period", tn - ts, d2 + 1);
            check("swap_ready", int'(cfg_ready), 1);
            check("swap_div", int'(bg_final_value), d2);
            dc = d2;
            t  = tn;
        end

        k = $urandom_range(1, dc);
        repeat (k) @(negedge clk);
        run = 1'b0;
        wait_tick(t2);
        check("drain_tick", t2 - t, dc + 1);
        @(negedge clk);
        check("drain_enable", int'(bg_enable), 0);
        check("drain_running", int'(running), 0);
        repeat ($urandom_range(2, 8)) @(negedge clk);
        start_and_measure(dc, "restart");

        wait_tick(t);
        d3 = dc + 1 + $urandom_range(0, 5);
        cfg_valid = 1'b1;
        cfg_div   = 16'(d3);
        run       = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        check("cfgstop_ready", int'(cfg_ready), 0);
        check("cfgstop_olddiv", int'(bg_final_value), dc);
        wait_tick(t2);
        check("cfgstop_tick", t2 - t, dc + 1);
        @(negedge clk);
        check("cfgstop_newdiv", int'(bg_final_value), d3);
        check("cfgstop_enable", int'(bg_enable), 0);
        check("cfgstop_rdy1", int'(cfg_ready), 1);
        start_and_measure(d3, "after_drain");
        dc = d3;

        wait_tick(t);
        p0 = to_pulses;
        df = dc + 3;
        cfg_valid = 1'b1;
        cfg_div   = 16'(df);
        link_busy = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (2 * TO) wait_tick(t);
`ifdef UART_BAUD_TIMEOUT_EN
        check("to_pulses", to_pulses - p0, 1);
        check("to_div", int'(bg_final_value), df);
`else
        check("to_pulses", to_pulses - p0, 0);
        check("to_div", int'(bg_final_value), dc);
        check("to_ready", int'(cfg_ready), 0);
`endif

        reset = 1'b1;
        #1;
        check("midrst_enable", int'(bg_enable), 0);
        check("midrst_running", int'(running), 0);
        check("midrst_ready", int'(cfg_ready), 1);
        check("midrst_div", int'(bg_final_value), 650);
        check("midrst_tick", int'(baud_tick), 0);
        @(negedge clk);
        run       = 1'b0;
        link_busy = 1'b0;
        reset     = 1'b0;
        repeat (5) @(negedge clk);
        check("postrst_running", int'(running), 0);
        check("postrst_div", int'(bg_final_value), 650);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
